// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch/countdown core: FSM states,
// seconds limit, count-direction encodings and a shift-based mm:ss -> seconds helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int   SEC_MAX   = 59;
  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // m*60 + s built from shifts so a preset never needs a multiplier
  function automatic int unsigned mmss_to_total(input int unsigned m, input int unsigned s);
    return (m << 6) - (m << 2) + s;
  endfunction

endpackage

// File: rtl/stopwatch_timer_sec_prescaler.sv
// Divides clk down to a one-cycle second tick; counts only while enabled and
// holds its phase otherwise, so a paused second resumes where it left off.
module sec_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic zero,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = en && !zero && w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (zero) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_timer.sv
// Stopwatch/countdown core: run/pause FSM, min:sec and total-seconds counters,
// expiry detection. Lap capture is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int MAX_MIN  = 99,
  parameter int MIN_W    = 7,
  parameter int TOT_W    = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             mode,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  input  logic             lap,
  output logic [MIN_W-1:0] min,
  output logic [5:0]       sec,
  output logic [TOT_W-1:0] totalsec,
  output logic             running,
  output logic             expired,
  output logic [MIN_W-1:0] lap_min,
  output logic [5:0]       lap_sec,
  output logic             lap_valid,
  output state_t           o_state
);

  localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);
  localparam logic [5:0]       SEC_MAX_V = 6'(SEC_MAX);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_mode;
  logic [MIN_W-1:0] r_min;
  logic [5:0]       r_sec;
  logic [TOT_W-1:0] r_tot;
  logic             r_running;
  logic             r_expired;

  logic             w_load_acc;
  logic             w_zero;
  logic             w_tick;
  logic             w_in_run;
  logic             w_at_zero;
  logic             w_at_one;
  logic             w_at_max;
  logic             w_term;
  logic             w_hold;
  logic             w_running_nxt;
  logic [MIN_W-1:0] w_ld_min;
  logic [5:0]       w_ld_sec;
  logic [TOT_W-1:0] w_ld_tot;

  // Preset path: clamp both fields before they reach the counters
  assign w_ld_min = (load_min > MAX_MIN_V) ? MAX_MIN_V : load_min;
  assign w_ld_sec = (load_sec > SEC_MAX_V) ? SEC_MAX_V : load_sec;
  assign w_ld_tot = TOT_W'(mmss_to_total(32'(w_ld_min), 32'(w_ld_sec)));

  assign w_in_run   = (r_state == ST_RUN);
  assign w_load_acc = load && !w_in_run;
  assign w_zero     = clear || w_load_acc;

  sec_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_in_run),
    .zero  (w_zero),
    .tick  (w_tick)
  );

  assign w_at_zero = (r_min == '0) && (r_sec == '0);
  assign w_at_one  = (r_min == '0) && (r_sec == 6'd1);
  assign w_at_max  = (r_min == MAX_MIN_V) && (r_sec == SEC_MAX_V);

  // A down count sitting at 0:00 expires without waiting for a tick
  assign w_term = w_in_run &&
                  (((r_mode == MODE_DOWN) && w_at_zero) ||
                   (w_tick && (r_mode == MODE_UP)   && w_at_max) ||
                   (w_tick && (r_mode == MODE_DOWN) && w_at_one));

  assign w_hold = ((r_mode == MODE_UP) && w_at_max) || ((r_mode == MODE_DOWN) && w_at_zero);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else if (w_load_acc) begin
      w_state_nxt = ST_PAUSE;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (start_stop) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (w_term)          w_state_nxt = ST_DONE;
          else if (start_stop) w_state_nxt = ST_PAUSE;
        end
        ST_PAUSE: if (start_stop) w_state_nxt = ST_RUN;
        ST_DONE:  w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM: output decode, registered below so running tracks the state it names
  always_comb begin
    w_running_nxt = (w_state_nxt == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_running <= 1'b0;
    end else begin
      r_running <= w_running_nxt;
    end
  end

  // Direction is frozen for the whole of a run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_UP;
    end else if (!w_in_run) begin
      r_mode <= mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '0;
      r_sec <= '0;
      r_tot <= '0;
    end else if (clear) begin
      r_min <= '0;
      r_sec <= '0;
      r_tot <= '0;
    end else if (w_load_acc) begin
      r_min <= w_ld_min;
      r_sec <= w_ld_sec;
      r_tot <= w_ld_tot;
    end else if (w_tick && !w_hold) begin
      if (r_mode == MODE_UP) begin
        if (r_sec == SEC_MAX_V) begin
          r_sec <= '0;
          r_min <= r_min + 1'b1;
        end else begin
          r_sec <= r_sec + 1'b1;
        end
        r_tot <= r_tot + 1'b1;
      end else begin
        if (r_sec == '0) begin
          r_sec <= SEC_MAX_V;
          r_min <= r_min - 1'b1;
        end else begin
          r_sec <= r_sec - 1'b1;
        end
        r_tot <= r_tot - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_expired <= 1'b0;
    end else if (w_zero) begin
      r_expired <= 1'b0;
    end else if (w_term) begin
      r_expired <= 1'b1;
    end
  end

  assign min      = r_min;
  assign sec      = r_sec;
  assign totalsec = r_tot;
  assign running  = r_running;
  assign expired  = r_expired;
  assign o_state  = r_state;

`ifdef STOPWATCH_LAP_EN
  logic             w_lap_take;
  logic [MIN_W-1:0] r_lap_min;
  logic [5:0]       r_lap_sec;
  logic             r_lap_valid;

  // Captures the registered (pre-tick) count when a lap lands on a tick
  assign w_lap_take = lap && !clear && !w_load_acc && !start_stop &&
                      ((r_state == ST_RUN) || (r_state == ST_PAUSE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap_min   <= '0;
      r_lap_sec   <= '0;
      r_lap_valid <= 1'b0;
    end else if (clear) begin
      r_lap_min   <= '0;
      r_lap_sec   <= '0;
      r_lap_valid <= 1'b0;
    end else if (w_lap_take) begin
      r_lap_min   <= r_min;
      r_lap_sec   <= r_sec;
      r_lap_valid <= 1'b1;
    end
  end

  assign lap_min   = r_lap_min;
  assign lap_sec   = r_lap_sec;
  assign lap_valid = r_lap_valid;
`else
  logic w_lap_unused;
  assign w_lap_unused = lap;
  assign lap_min      = '0;
  assign lap_sec      = '0;
  assign lap_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timer.sv
// Bench for stopwatch_timer (TICK_DIV=4, MAX_MIN=2): directed scenarios plus a
// randomized run against a total-seconds reference model.
module tb_stopwatch_timer;
  import stopwatch_pkg::*;

  localparam int TD      = 4;
  localparam int MM      = 2;
  localparam int MIN_W   = 7;
  localparam int TOT_W   = 13;
  localparam int TOT_MAX = MM * 60 + 59;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_stop = 1'b0;
  logic             clear = 1'b0;
  logic             mode = 1'b0;
  logic             load = 1'b0;
  logic [MIN_W-1:0] load_min = '0;
  logic [5:0]       load_sec = '0;
  logic             lap = 1'b0;
  logic [MIN_W-1:0] min;
  logic [5:0]       sec;
  logic [TOT_W-1:0] totalsec;
  logic             running;
  logic             expired;
  logic [MIN_W-1:0] lap_min;
  logic [5:0]       lap_sec;
  logic             lap_valid;
  state_t           o_state;

  int n_total = 0;
  int n_bad   = 0;

  // reference model: count kept as total seconds
  state_t m_state = ST_IDLE;
  int     m_phase = 0;
  int     m_tot   = 0;
  bit     m_mode  = 0;
  bit     m_exp   = 0;
  int     m_lmin  = 0;
  int     m_lsec  = 0;
  bit     m_lv    = 0;

  stopwatch_timer #(
    .TICK_DIV (TD),
    .MAX_MIN  (MM),
    .MIN_W    (MIN_W),
    .TOT_W    (TOT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .mode       (mode),
    .load       (load),
    .load_min   (load_min),
    .load_sec   (load_sec),
    .lap        (lap),
    .min        (min),
    .sec        (sec),
    .totalsec   (totalsec),
    .running    (running),
    .expired    (expired),
    .lap_min    (lap_min),
    .lap_sec    (lap_sec),
    .lap_valid  (lap_valid),
    .o_state    (o_state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = ST_IDLE; m_phase = 0; m_tot = 0; m_mode = 0; m_exp = 0;
    m_lmin = 0; m_lsec = 0; m_lv = 0;
  endtask

  // One clock edge; the model advances from the inputs seen before the edge
  task automatic step();
    state_t ns;
    int     nph, ntot, nlmin, nlsec, cm, cs;
    bit     nmode, nexp, nlv, term;
    ns = m_state; nph = m_phase; ntot = m_tot; nmode = m_mode; nexp = m_exp;
    nlmin = m_lmin; nlsec = m_lsec; nlv = m_lv; term = 0;
    if (m_state != ST_RUN) nmode = mode;
    if (clear) begin
      ns = ST_IDLE; nph = 0; ntot = 0; nexp = 0; nlmin = 0; nlsec = 0; nlv = 0;
    end else if (load && m_state != ST_RUN) begin
      cm = (int'(load_min) > MM) ? MM : int'(load_min);
      cs = (int'(load_sec) > 59) ? 59 : int'(load_sec);
      ntot = cm * 60 + cs; nph = 0; nexp = 0; ns = ST_PAUSE;
    end else begin
      if (m_state == ST_RUN) begin
        nph = (m_phase + 1) % TD;
        if (m_mode && m_tot == 0) term = 1;
        else if (m_phase == TD - 1) begin
          if (!m_mode) begin
            if (m_tot == TOT_MAX) term = 1;
            else ntot = m_tot + 1;
          end else begin
            ntot = m_tot - 1;
            if (ntot == 0) term = 1;
          end
        end
      end
      if (term) begin
        ns = ST_DONE; nexp = 1;
      end else if (start_stop) begin
        if (m_state == ST_IDLE || m_state == ST_PAUSE) ns = ST_RUN;
        else if (m_state == ST_RUN) ns = ST_PAUSE;
      end
`ifdef STOPWATCH_LAP_EN
      if (lap && !start_stop && (m_state == ST_RUN || m_state == ST_PAUSE)) begin
        nlmin = m_tot / 60; nlsec = m_tot % 60; nlv = 1;
      end
`endif
    end
    @(posedge clk);
    #1;
    m_state = ns; m_phase = nph; m_tot = ntot; m_mode = nmode; m_exp = nexp;
    m_lmin = nlmin; m_lsec = nlsec; m_lv = nlv;
  endtask

  task automatic pulse_start();
    start_stop = 1'b1; step(); start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic pulse_load(input int m, input int s);
    load_min = MIN_W'(m); load_sec = 6'(s);
    load = 1'b1; step(); load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (min !== 7'd0) begin n_bad++; $display("FAIL reset_min: got %0d want 0", min); end
    n_total++; if (sec !== 6'd0) begin n_bad++; $display("FAIL reset_sec: got %0d want 0", sec); end
    n_total++; if (totalsec !== 13'd0) begin n_bad++; $display("FAIL reset_tot: got %0d want 0", totalsec); end
    n_total++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %0b want 0", running); end
    n_total++; if (expired !== 1'b0) begin n_bad++; $display("FAIL reset_expired: got %0b want 0", expired); end
    n_total++; if (lap_valid !== 1'b0) begin n_bad++; $display("FAIL reset_lap_valid: got %0b want 0", lap_valid); end
    n_total++; if (o_state !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", o_state, ST_IDLE); end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_up_count();
    mode = 1'b0;
    pulse_start();
    n_total++; if (running !== 1'b1) begin n_bad++; $display("FAIL up_running_rise: got %0b want 1", running); end
    n_total++; if (totalsec !== 13'd0) begin n_bad++; $display("FAIL up_first_cycle: got %0d want 0", totalsec); end
    repeat (TD * 60) step();
    n_total++; if (min !== 7'd1) begin n_bad++; $display("FAIL up_min: got %0d want 1", min); end
    n_total++; if (sec !== 6'd0) begin n_bad++; $display("FAIL up_sec: got %0d want 0", sec); end
    n_total++; if (totalsec !== 13'd60) begin n_bad++; $display("FAIL up_tot: got %0d want 60", totalsec); end
    n_total++; if (running !== 1'b1) begin n_bad++; $display("FAIL up_running: got %0b want 1", running); end
  endtask

  task automatic test_pause_resume();
    int changed;
    step();
    pulse_start();
    n_total++; if (running !== 1'b0) begin n_bad++; $display("FAIL pause_running: got %0b want 0", running); end
    changed = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (totalsec !== 13'd60) changed++;
    end
    n_total++; if (changed != 0) begin n_bad++; $display("FAIL pause_hold: got %0d changed cycles want 0", changed); end
    pulse_start();
    n_total++; if (running !== 1'b1) begin n_bad++; $display("FAIL resume_running: got %0b want 1", running); end
    step();
    n_total++; if (totalsec !== 13'd60) begin n_bad++; $display("FAIL resume_early: got %0d want 60", totalsec); end
    step();
    n_total++; if (totalsec !== 13'd61 || sec !== 6'd1) begin
      n_bad++; $display("FAIL resume_tick: got %0d (sec %0d) want 61 (sec 1)", totalsec, sec);
    end
  endtask

  task automatic test_up_saturation();
    mode = 1'b0;
    pulse_load(2, 58);
    n_total++; if (min !== 7'd2 || sec !== 6'd58 || o_state !== ST_PAUSE) begin
      n_bad++; $display("FAIL sat_load: got %0d:%0d st %0d want 2:58 st %0d", min, sec, o_state, ST_PAUSE);
    end
    pulse_start();
    repeat (TD) step();
    n_total++; if (sec !== 6'd59 || expired !== 1'b0) begin
      n_bad++; $display("FAIL sat_first: got sec %0d exp %0b want 59 0", sec, expired);
    end
    repeat (TD) step();
    n_total++; if (min !== 7'd2 || sec !== 6'd59 || totalsec !== 13'd179) begin
      n_bad++; $display("FAIL sat_hold: got %0d:%0d tot %0d want 2:59 tot 179", min, sec, totalsec);
    end
    n_total++; if (expired !== 1'b1 || o_state !== ST_DONE || running !== 1'b0) begin
      n_bad++; $display("FAIL sat_done: got exp %0b st %0d run %0b want 1 %0d 0", expired, o_state, running, ST_DONE);
    end
    pulse_start();
    repeat (3) step();
    n_total++; if (o_state !== ST_DONE || running !== 1'b0) begin
      n_bad++; $display("FAIL sat_ignore_start: got st %0d run %0b want %0d 0", o_state, running, ST_DONE);
    end
  endtask

  task automatic test_countdown();
    mode = 1'b1;
    pulse_load(0, 2);
    pulse_start();
    repeat (TD) step();
    n_total++; if (totalsec !== 13'd1 || sec !== 6'd1 || expired !== 1'b0) begin
      n_bad++; $display("FAIL down_one: got tot %0d sec %0d exp %0b want 1 1 0", totalsec, sec, expired);
    end
    repeat (TD) step();
    n_total++; if (totalsec !== 13'd0 || expired !== 1'b1 || o_state !== ST_DONE) begin
      n_bad++; $display("FAIL down_zero: got tot %0d exp %0b st %0d want 0 1 %0d", totalsec, expired, o_state, ST_DONE);
    end
    pulse_clear();
    n_total++; if (totalsec !== 13'd0 || min !== 7'd0 || sec !== 6'd0 || expired !== 1'b0 || o_state !== ST_IDLE) begin
      n_bad++; $display("FAIL down_clear: got tot %0d exp %0b st %0d want 0 0 %0d", totalsec, expired, o_state, ST_IDLE);
    end
    // down start from 0:00 finishes one cycle after running rises
    pulse_start();
    n_total++; if (running !== 1'b1) begin n_bad++; $display("FAIL down_zero_start: got run %0b want 1", running); end
    step();
    n_total++; if (o_state !== ST_DONE || expired !== 1'b1 || running !== 1'b0) begin
      n_bad++; $display("FAIL down_zero_done: got st %0d exp %0b run %0b want %0d 1 0", o_state, expired, running, ST_DONE);
    end
    pulse_clear();
    mode = 1'b0;
  endtask

  task automatic test_clamp_priority();
    pulse_load(7, 63);
    n_total++; if (min !== 7'd2 || sec !== 6'd59 || totalsec !== 13'd179) begin
      n_bad++; $display("FAIL clamp: got %0d:%0d tot %0d want 2:59 tot 179", min, sec, totalsec);
    end
    clear = 1'b1; pulse_load(1, 30); clear = 1'b0;
    n_total++; if (totalsec !== 13'd0 || o_state !== ST_IDLE) begin
      n_bad++; $display("FAIL clear_over_load: got tot %0d st %0d want 0 %0d", totalsec, o_state, ST_IDLE);
    end
    pulse_start();
    pulse_load(1, 10);
    n_total++; if (totalsec !== 13'd0 || o_state !== ST_RUN || running !== 1'b1) begin
      n_bad++; $display("FAIL load_in_run: got tot %0d st %0d run %0b want 0 %0d 1", totalsec, o_state, running, ST_RUN);
    end
    pulse_clear();
  endtask

  task automatic test_lap();
    mode = 1'b0;
    pulse_start();
    repeat (5 * TD) step();
    lap = 1'b1; step(); lap = 1'b0;
`ifdef STOPWATCH_LAP_EN
    n_total++; if (lap_min !== 7'd0 || lap_sec !== 6'd5 || lap_valid !== 1'b1) begin
      n_bad++; $display("FAIL lap_capture: got %0d:%0d v %0b want 0:5 v 1", lap_min, lap_sec, lap_valid);
    end
    repeat (TD - 1) step();
    n_total++; if (totalsec !== 13'd6 || running !== 1'b1) begin
      n_bad++; $display("FAIL lap_continue: got tot %0d run %0b want 6 1", totalsec, running);
    end
    repeat (TD - 1) step();
    lap = 1'b1; step(); lap = 1'b0;
    n_total++; if (lap_sec !== 6'd6 || totalsec !== 13'd7) begin
      n_bad++; $display("FAIL lap_on_tick: got lap %0d tot %0d want 6 7", lap_sec, totalsec);
    end
    pulse_clear();
    lap = 1'b1; step(); lap = 1'b0;
    n_total++; if (lap_valid !== 1'b0) begin n_bad++; $display("FAIL lap_idle: got v %0b want 0", lap_valid); end
`else
    n_total++; if (lap_min !== 7'd0 || lap_sec !== 6'd0 || lap_valid !== 1'b0) begin
      n_bad++; $display("FAIL lap_tied: got %0d:%0d v %0b want 0:0 v 0", lap_min, lap_sec, lap_valid);
    end
    n_total++; if (totalsec !== 13'd5 || running !== 1'b1) begin
      n_bad++; $display("FAIL lap_ignored: got tot %0d run %0b want 5 1", totalsec, running);
    end
    pulse_clear();
`endif
  endtask

  task automatic test_async_reset();
    pulse_start();
    repeat (3 * TD + 1) step();
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (totalsec !== 13'd0 || min !== 7'd0 || sec !== 6'd0 || running !== 1'b0 ||
                   expired !== 1'b0 || lap_valid !== 1'b0 || o_state !== ST_IDLE) begin
      n_bad++; $display("FAIL async_reset: got tot %0d run %0b st %0d want 0 0 %0d", totalsec, running, o_state, ST_IDLE);
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++; if (o_state !== ST_IDLE || totalsec !== 13'd0) begin
      n_bad++; $display("FAIL async_release: got st %0d tot %0d want %0d 0", o_state, totalsec, ST_IDLE);
    end
  endtask

  task automatic test_random();
    int r;
    bit risky;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199);
      risky = (m_state == ST_RUN) && ((m_phase == TD - 1) || (m_mode && m_tot == 0));
      mode = 1'($urandom_range(0, 1));
      load_min = MIN_W'($urandom_range(0, 7));
      load_sec = 6'($urandom_range(0, 63));
      if (r < 6) start_stop = !risky;
      else if (r < 8) load = 1'b1;
      else if (r == 8) clear = 1'b1;
      else if (r < 13) lap = 1'b1;
      step();
      start_stop = 1'b0; load = 1'b0; clear = 1'b0; lap = 1'b0;
      n_total++; if (totalsec !== 13'(m_tot)) begin n_bad++; $display("FAIL rnd_tot@%0d: got %0d want %0d", i, totalsec, m_tot); end
      n_total++; if (min !== 7'(m_tot / 60)) begin n_bad++; $display("FAIL rnd_min@%0d: got %0d want %0d", i, min, m_tot / 60); end
      n_total++; if (sec !== 6'(m_tot % 60)) begin n_bad++; $display("FAIL rnd_sec@%0d: got %0d want %0d", i, sec, m_tot % 60); end
      n_total++; if (running !== (m_state == ST_RUN)) begin n_bad++; $display("FAIL rnd_running@%0d: got %0b want %0b", i, running, m_state == ST_RUN); end
      n_total++; if (expired !== m_exp) begin n_bad++; $display("FAIL rnd_expired@%0d: got %0b want %0b", i, expired, m_exp); end
      n_total++; if (o_state !== m_state) begin n_bad++; $display("FAIL rnd_state@%0d: got %0d want %0d", i, o_state, m_state); end
      n_total++; if (lap_valid !== m_lv || lap_min !== 7'(m_lmin) || lap_sec !== 6'(m_lsec)) begin
        n_bad++; $display("FAIL rnd_lap@%0d: got %0d:%0d v %0b want %0d:%0d v %0b", i, lap_min, lap_sec, lap_valid, m_lmin, m_lsec, m_lv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_pause_resume();
    pulse_clear();
    test_up_saturation();
    test_countdown();
    test_clamp_priority();
    test_lap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
